// File: rtl/ipsxe_floating_point_norm_grs_v1_0.sv
// Iterative leading-zero normalizer producing fraction plus round/sticky bits
// for the downstream round-to-nearest-even stage.
module ipsxe_floating_point_norm_grs_v1_0 #(
  parameter int W    = 23,
  parameter int RNE  = 5,
  parameter int IW   = 48,
  parameter int EW   = 8,
  parameter int STEP = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [IW-1:0]     i_mant,
  input  logic [EW+1:0]     i_exp,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [W+RNE-1:0]  o_before_rne,
  output logic [EW+1:0]     o_exp,
  output logic              o_zero
);

  localparam int XW  = EW + 2;
  localparam int OW  = W + RNE;
  localparam int LZW = $clog2(STEP + 1);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   m_q, m_d;
  logic [XW-1:0]   e_q, e_d;
  logic [OW-1:0]   frac_q, frac_d;
  logic [XW-1:0]   exp_q, exp_d;
  logic            zero_q, zero_d;

  logic [LZW-1:0]  lz;
  logic            found;
  logic [OW-1:0]   frac_pack;

  // Leading zeros in the top STEP bits; STEP means the window is empty.
  always_comb begin
    lz    = LZW'(STEP);
    found = 1'b0;
    for (int i = 0; i < STEP; i++) begin
      if (!found && m_q[IW-1-i]) begin
        lz    = LZW'(i);
        found = 1'b1;
      end
    end
  end

  // Hidden bit dropped; everything under the kept field folds into sticky.
  assign frac_pack = {m_q[IW-2 -: OW-1], |m_q[IW-OW-1:0]};

  assign o_ready = (state_q == IDLE) & ~i_rst;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    e_d     = e_q;
    frac_d  = frac_q;
    exp_d   = exp_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (i_valid && o_ready) begin
          m_d = i_mant;
          e_d = i_exp;
          if (i_mant == '0) begin
            state_d = DONE;
            zero_d  = 1'b1;
            frac_d  = '0;
            exp_d   = '0;
          end else begin
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (lz == '0) begin
          state_d = DONE;
          frac_d  = frac_pack;
          exp_d   = e_q;
          zero_d  = 1'b0;
        end else begin
          m_d = m_q << lz;
          e_d = e_q - XW'(lz);
        end
      end
      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      e_q     <= '0;
      frac_q  <= '0;
      exp_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      e_q     <= e_d;
      frac_q  <= frac_d;
      exp_q   <= exp_d;
      zero_q  <= zero_d;
    end
  end

  assign o_valid      = (state_q == DONE);
  assign o_before_rne = frac_q;
  assign o_exp        = exp_q;
  assign o_zero       = zero_q;

endmodule

// File: tb/tb_ipsxe_floating_point_norm_grs_v1_0.sv
// Vector table plus scoreboard checks for the normalizer, including
// backpressure and reset corner sequences.
module tb_ipsxe_floating_point_norm_grs_v1_0;

  typedef struct {
    logic [47:0] mant;
    logic [9:0]  iexp;
    logic [27:0] frac;
    logic [9:0]  oexp;
    logic        zero;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [47:0] i_mant;
  logic [9:0]  i_exp;
  logic        o_valid;
  logic        i_ready;
  logic [27:0] o_before_rne;
  logic [9:0]  o_exp;
  logic        o_zero;

  int total = 0;
  int bad   = 0;

  vec_t sb[$];
  vec_t tbl[16];

  ipsxe_floating_point_norm_grs_v1_0 dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_mant      (i_mant),
    .i_exp       (i_exp),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_before_rne(o_before_rne),
    .o_exp       (o_exp),
    .o_zero      (o_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, a, x);
    end
  endtask

  function automatic vec_t model(input logic [47:0] m, input logic [9:0] e);
    vec_t r;
    int   l;
    r.mant = m;
    r.iexp = e;
    if (m == 0) begin
      r.frac = '0;
      r.oexp = '0;
      r.zero = 1'b1;
      r.lat  = 0;
    end else begin
      l = 0;
      while (!m[47]) begin
        m = m << 1;
        l++;
      end
      r.frac = {m[46:20], |m[19:0]};
      r.oexp = e - 10'(l);
      r.zero = 1'b0;
      r.lat  = (l + 3) / 4 + 1;
    end
    return r;
  endfunction

  task automatic run_op(input vec_t v, input int hold);
    int          n;
    bit          got;
    vec_t        x;
    logic [27:0] sf;
    logic [9:0]  se;
    logic        sz;
    @(negedge clk);
    i_valid = 1'b1;
    i_mant  = v.mant;
    i_exp   = v.iexp;
    n = 0;
    while (!o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_in", 64'(o_ready), 64'd1);
    sb.push_back(v);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_mant  = {16'($urandom), $urandom};
    i_ready = (hold == 0);
    n   = 0;
    got = 1'b0;
    while (n < 100 && !got) begin
      @(negedge clk);
      n++;
      got = o_valid;
    end
    chk("valid_seen", 64'(got), 64'd1);
    if (sb.size() > 0) x = sb.pop_front();
    else x = v;
    if (got) begin
      chk("latency", 64'(n - 1), 64'(x.lat));
      chk("frac", 64'(o_before_rne), 64'(x.frac));
      chk("exp", 64'(o_exp), 64'(x.oexp));
      chk("zero", 64'(o_zero), 64'(x.zero));
      if (hold > 0) begin
        sf = o_before_rne;
        se = o_exp;
        sz = o_zero;
        i_valid = 1'b1;
        i_mant  = 48'h0000_FFFF_0000;
        i_exp   = 10'd77;
        for (int k = 0; k < hold; k++) begin
          @(negedge clk);
          chk("bp_valid", 64'(o_valid), 64'd1);
          chk("bp_ready", 64'(o_ready), 64'd0);
          chk("bp_stable", {32'(sf), 16'(se), 16'(sz)},
              {32'(o_before_rne), 16'(o_exp), 16'(o_zero)});
        end
        i_ready = 1'b1;
        i_valid = 1'b0;
      end
      @(negedge clk);
      chk("post_valid", 64'(o_valid), 64'd0);
      chk("post_ready", 64'(o_ready), 64'd1);
    end
  endtask

  task automatic idle_watch(input string nm, input int cyc);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < cyc; k++) begin
      @(negedge clk);
      if (o_valid) seen = 1'b1;
    end
    chk(nm, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [47:0] rm;
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_mant  = '0;
    i_exp   = '0;
    i_ready = 1'b1;

    tbl[0] = '{48'h8000_0000_0001, 10'd10, 28'h0000001, 10'd10,  1'b0, 1};
    tbl[1] = '{48'h0C00_0000_0000, 10'd20, 28'h8000000, 10'd16,  1'b0, 2};
    tbl[2] = '{48'h0000_0000_0001, 10'd10, 28'h0000000, 10'h3DB, 1'b0, 13};
    tbl[3] = '{48'h0000_0000_0000, 10'd55, 28'h0000000, 10'd0,   1'b1, 0};
    tbl[4] = '{48'h1FFF_FFFF_FFFF, 10'd0,  28'hFFFFFFF, 10'h3FD, 1'b0, 2};
    tbl[5] = '{48'h0400_0000_0000, 10'd20, 28'h0000000, 10'd15,  1'b0, 3};
    tbl[6] = '{48'h8000_0010_0000, 10'd3,  28'h0000002, 10'd3,   1'b0, 1};
    tbl[7] = '{48'h8000_0008_0000, 10'd3,  28'h0000001, 10'd3,   1'b0, 1};
    tbl[8] = '{48'h0000_0000_0001, 10'd0,  28'h0000000, 10'h3D1, 1'b0, 13};
    tbl[9] = '{48'hC000_0000_0000, 10'h3FF, 28'h8000000, 10'h3FF, 1'b0, 1};
    for (int i = 10; i < 16; i++) begin
      rm = {16'($urandom), $urandom} >> $urandom_range(0, 47);
      if (rm == 0) rm = 48'h1;
      tbl[i] = model(rm, 10'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(o_ready), 64'd0);
    chk("rst_valid", 64'(o_valid), 64'd0);
    @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    chk("rst_ready_rel", 64'(o_ready), 64'd1);
    chk("rst_outs", {32'(o_before_rne), 16'(o_exp), 16'(o_zero)}, 64'd0);

    for (int i = 0; i < 16; i++) run_op(tbl[i], 0);

    run_op(tbl[1], 5);

    run_op(tbl[4], 0);
    @(negedge clk);
    i_valid = 1'b1;
    i_mant  = tbl[2].mant;
    i_exp   = tbl[2].iexp;
    @(posedge clk);
    #1 i_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 i_rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 64'(o_ready), 64'd0);
    @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 64'(o_valid), 64'd0);
    chk("midrst_outs", {32'(o_before_rne), 16'(o_exp), 16'(o_zero)}, 64'd0);
    chk("midrst_ready_rel", 64'(o_ready), 64'd1);
    idle_watch("midrst_no_out", 20);
    run_op(tbl[0], 0);

    @(negedge clk);
    i_rst   = 1'b1;
    i_valid = 1'b1;
    i_mant  = tbl[1].mant;
    i_exp   = tbl[1].iexp;
    @(posedge clk);
    #1;
    i_rst   = 1'b0;
    i_valid = 1'b0;
    idle_watch("rst_hs_no_out", 10);
    chk("rst_hs_ready", 64'(o_ready), 64'd1);
    run_op(tbl[3], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
